// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the calculator's iterative divider.
package calc_pkg;

  localparam int N_DEF = 8;
  localparam int CNT_W = $clog2(2 * N_DEF + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake plus operand and result bus between sequencer and divider.
interface seq_divider_if
  import calc_pkg::*;
#(
  parameter int N = N_DEF
);

  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             busy;
  logic             done;
  logic             div0;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div0, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div0, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift a dividend bit into the partial remainder, subtract if it fits.
module div_step
  import calc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   pr_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   pr_o,
  output logic         q_o
);

  logic [N:0] shifted;
  // The incoming pr is always below the divisor, so its MSB carries no information.
  logic       unused_pr_msb;

  assign unused_pr_msb = pr_i[N];

  always_comb begin
    shifted = {pr_i[N-1:0], bit_i};
    pr_o    = shifted;
    q_o     = 1'b0;
    if (shifted >= {1'b0, divisor_i}) begin
      pr_o = shifted - {1'b0, divisor_i};
      q_o  = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_divider
  import calc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_e           state_q, state_d;
  logic [2*N-1:0]   dq_q, dq_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N:0]       pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [2*N-1:0]   quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;

  logic [N:0]       step_pr;
  logic             step_q;

  div_step #(.N(N)) u_step (
    .pr_i      (pr_q),
    .bit_i     (dq_q[2*N-1]),
    .divisor_i (dvs_q),
    .pr_o      (step_pr),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            dq_d    = bus.dividend;
            dvs_d   = bus.divisor;
            pr_d    = '0;
            cnt_d   = CW'(2 * N);
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            quo_d   = '1;
            rem_d   = '0;
            div0_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        pr_d  = step_pr;
        dq_d  = {dq_q[2*N-2:0], step_q};
        cnt_d = cnt_q - CW'(1);
        // Results are taken straight from the final step so done lands on the same edge.
        if (cnt_q == CW'(1)) begin
          quo_d   = {dq_q[2*N-2:0], step_q};
          rem_d   = step_pr[N-1:0];
          div0_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dq_q    <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div0      = div0_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule
